// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : regfile_pkg                                                 |
// | Purpose : Shared defaults and helpers for the scoreboarded register   |
// |           file (regfile_sb and regfile_scoreboard).                   |
// | Contents: XLEN_DEFAULT, NREGS_DEFAULT, reg_valid()                    |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  // True for a real, writable register: nonzero and below nregs.
  // Register 0 and any address past the end behave identically.
  function automatic logic reg_valid(input logic [5:0] addr, input int nregs);
    return (addr != 6'd0) && (int'(addr) < nregs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : regfile_scoreboard                                          |
// | Purpose : Pending-destination tracking for the register file.         |
// |           Holds the busy vector, issue acceptance, set/clear priority,|
// |           the registered pending count and the stray write-back flag. |
// | Ports   : clk, reset        - clock, sync active-high reset           |
// |           rs_addr/rs_busy   - per-read-port pending status            |
// |           issue_valid/rd    - issuing destination, issue_ready back   |
// |           wb_valid/wb_rd    - write-back destination                  |
// |           busy_count        - registered popcount of busy vector      |
// |           wb_err            - registered write-back-to-idle pulse     |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREAD*AW-1:0] rs_addr,
  output logic [NREAD-1:0]    rs_busy,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  output logic                issue_ready,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_rd,
  output logic [AW:0]         busy_count,
  output logic                wb_err
);

  localparam int NSLOT = 1 << AW;

  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      count_q, count_d;
  logic             err_q, err_d;
  logic [NSLOT-1:0] w_busy_ext;
  logic             w_wb_go;
  logic             w_issue_go;

  // Zero-extended to the full address space so out-of-range addresses
  // read as idle. Bit 0 is never set, so register 0 is always idle too.
  assign w_busy_ext = NSLOT'(busy_q);

  assign w_wb_go     = wb_valid && reg_valid(6'(wb_rd), NREGS);
  // A write-back to the same register this cycle frees the slot in time.
  assign issue_ready = !w_busy_ext[issue_rd] || (wb_valid && (wb_rd == issue_rd));
  assign w_issue_go  = issue_valid && issue_ready && reg_valid(6'(issue_rd), NREGS);

  always_comb begin
    busy_d  = busy_q;
    count_d = '0;
    // Clear first, then set: a same-cycle reissue keeps the bit pending
    // because a new producer is outstanding.
    for (int i = 0; i < NREGS; i++) begin
      if (w_wb_go && (wb_rd == AW'(i)))
        busy_d[i] = 1'b0;
      if (w_issue_go && (issue_rd == AW'(i)))
        busy_d[i] = 1'b1;
    end
    for (int i = 0; i < NREGS; i++)
      count_d = count_d + (AW+1)'(busy_d[i]);
    err_d = w_wb_go && !w_busy_ext[wb_rd];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign busy_count = count_q;
  assign wb_err     = err_q;

  for (genvar i = 0; i < NREAD; i++) begin : g_busy
    logic [AW-1:0] w_addr;
    assign w_addr     = rs_addr[i*AW +: AW];
    assign rs_busy[i] = w_busy_ext[w_addr] &&
                        !((BYPASS != 0) && wb_valid && (wb_rd == w_addr));
  end

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : regfile_sb                                                  |
// | Purpose : Integer register file with integrated scoreboard. NREAD     |
// |           combinational read ports with optional write-back bypass,   |
// |           one write-back port and one issue port.                     |
// | Ports   : clk, reset               - clock, sync active-high reset    |
// |           rs_addr/rs_data/rs_busy  - read ports (port i packed at i)  |
// |           issue_valid/rd/ready     - issue handshake                  |
// |           wb_valid/wb_rd/wb_data   - write-back                       |
// |           busy_count, wb_err       - registered scoreboard status     |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEFAULT,
  parameter  int NREGS  = NREGS_DEFAULT,
  parameter  int NREAD  = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rs_addr,
  output logic [NREAD*XLEN-1:0] rs_data,
  output logic [NREAD-1:0]      rs_busy,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rd,
  output logic                  issue_ready,
  input  logic                  wb_valid,
  input  logic [AW-1:0]         wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic [AW:0]           busy_count,
  output logic                  wb_err
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic            w_wb_go;

  assign w_wb_go = wb_valid && reg_valid(6'(wb_rd), NREGS);

  // Entry 0 is never written, so it holds its reset value of zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NREGS; k++)
        mem_q[k] <= '0;
    end else begin
      for (int k = 0; k < NREGS; k++)
        if (w_wb_go && (wb_rd == AW'(k)))
          mem_q[k] <= wb_data;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_read
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    assign w_addr = rs_addr[i*AW +: AW];
    always_comb begin
      w_data = '0;
      if (reg_valid(6'(w_addr), NREGS)) begin
        if ((BYPASS != 0) && wb_valid && (wb_rd == w_addr))
          w_data = wb_data;
        else
          w_data = mem_q[w_addr];
      end
    end
    assign rs_data[i*XLEN +: XLEN] = w_data;
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NREAD  (NREAD),
    .BYPASS (BYPASS),
    .AW     (AW)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .rs_addr     (rs_addr),
    .rs_busy     (rs_busy),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .busy_count  (busy_count),
    .wb_err      (wb_err)
  );

endmodule
`default_nettype wire
